stream_demux1to2: RTL and testbench

//  1-to-2 stream demultiplexer, the inverse of the mux2to1_d data path.

---
 rtl/stream_demux1to2.sv | 146 ++++++++++++++
 tb/tb_stream_demux1to2.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux1to2.sv
// 1-to-2 valid/ready packet demultiplexer with one register slot per output.
// Optional per-output packet counters are enabled with `define DEMUX_STATS_EN.
module stream_demux1to2 #(
  parameter int unsigned DATA_W = 8
`ifdef DEMUX_STATS_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_last,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_last
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0]  out0_pkt_cnt,
  output logic [CNT_W-1:0]  out1_pkt_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT0 = 2'd1,
    ST_PKT1 = 2'd2
  } state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  state_t r_state;

  logic  r_out0_valid;
  beat_t r_out0_beat;
  logic  r_out1_valid;
  beat_t r_out1_beat;

  logic  w_target;
  logic  w_accept;
  logic  w_load0;
  logic  w_load1;
  logic  w_drain0;
  logic  w_drain1;
  beat_t w_in_beat;

  // sel only matters on the first beat; mid-packet the locked output wins
  assign w_target  = (r_state == ST_IDLE) ? sel : (r_state == ST_PKT1);
  assign in_ready  = w_target ? (!r_out1_valid || out1_ready)
                              : (!r_out0_valid || out0_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_load0   = w_accept && !w_target;
  assign w_load1   = w_accept && w_target;
  assign w_drain0  = r_out0_valid && out0_ready;
  assign w_drain1  = r_out1_valid && out1_ready;
  assign w_in_beat = '{last: in_last, data: in_data};

  // Packet-lock FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (!in_last) begin
            r_state <= sel ? ST_PKT1 : ST_PKT0;
          end
        end
        ST_PKT0, ST_PKT1: begin
          if (in_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output slot 0: a refill takes priority over a drain in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out0_valid <= 1'b0;
      r_out0_beat  <= '0;
    end else if (w_load0) begin
      r_out0_valid <= 1'b1;
      r_out0_beat  <= w_in_beat;
    end else if (w_drain0) begin
      r_out0_valid <= 1'b0;
    end
  end

  // Output slot 1
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out1_valid <= 1'b0;
      r_out1_beat  <= '0;
    end else if (w_load1) begin
      r_out1_valid <= 1'b1;
      r_out1_beat  <= w_in_beat;
    end else if (w_drain1) begin
      r_out1_valid <= 1'b0;
    end
  end

  assign out0_valid = r_out0_valid;
  assign out0_data  = r_out0_beat.data;
  assign out0_last  = r_out0_beat.last;
  assign out1_valid = r_out1_valid;
  assign out1_data  = r_out1_beat.data;
  assign out1_last  = r_out1_beat.last;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] r_out0_pkt_cnt;
  logic [CNT_W-1:0] r_out1_pkt_cnt;

  // Saturating count of packets that completed on each output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out0_pkt_cnt <= '0;
      r_out1_pkt_cnt <= '0;
    end else begin
      if (w_drain0 && r_out0_beat.last && (r_out0_pkt_cnt != {CNT_W{1'b1}})) begin
        r_out0_pkt_cnt <= r_out0_pkt_cnt + CNT_W'(1);
      end
      if (w_drain1 && r_out1_beat.last && (r_out1_pkt_cnt != {CNT_W{1'b1}})) begin
        r_out1_pkt_cnt <= r_out1_pkt_cnt + CNT_W'(1);
      end
    end
  end

  assign out0_pkt_cnt = r_out0_pkt_cnt;
  assign out1_pkt_cnt = r_out1_pkt_cnt;
`endif

endmodule

// File: tb/tb_stream_demux1to2.sv
// Scoreboard bench for stream_demux1to2; per-output expected beat queues
// are filled on input acceptance and drained by an output monitor.
module tb_stream_demux1to2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       sel;
  logic       out0_valid;
  logic       out0_ready;
  logic [7:0] out0_data;
  logic       out0_last;
  logic       out1_valid;
  logic       out1_ready;
  logic [7:0] out1_data;
  logic       out1_last;
`ifdef DEMUX_STATS_EN
  logic [15:0] out0_pkt_cnt;
  logic [15:0] out1_pkt_cnt;
`endif

  always #5 clk = ~clk;

  stream_demux1to2 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .sel        (sel),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last)
`ifdef DEMUX_STATS_EN
    ,
    .out0_pkt_cnt (out0_pkt_cnt),
    .out1_pkt_cnt (out1_pkt_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int h0 = 0;
  int h1 = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int m_state = 0;   // 0 idle, 1 locked to out0, 2 locked to out1
  bit rand_on = 1'b0;

  // Reference routing model, called when a beat is accepted
  function automatic void model_accept(input logic [7:0] d, input logic l, input logic s);
    logic tgt;
    tgt = (m_state == 0) ? s : (m_state == 2);
    if (tgt) q1.push_back({l, d});
    else     q0.push_back({l, d});
    if (m_state == 0) begin
      if (!l) m_state = s ? 2 : 1;
    end else if (l) begin
      m_state = 0;
    end
  endfunction

  function automatic void model_reset();
    q0.delete();
    q1.delete();
    m_state = 0;
  endfunction

  // Output monitor: handshake seen here completes on the next rising edge
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst !== 1'b1) begin
      if (out0_valid === 1'b1 && out0_ready === 1'b1) begin
        h0++;
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL out0_unexpected got=%h", {out0_last, out0_data});
        end else begin
          e = q0.pop_front();
          if ({out0_last, out0_data} !== e) begin
            errors++;
            $display("FAIL out0_beat got=%h exp=%h", {out0_last, out0_data}, e);
          end
        end
      end
      if (out1_valid === 1'b1 && out1_ready === 1'b1) begin
        h1++;
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL out1_unexpected got=%h", {out1_last, out1_data});
        end else begin
          e = q1.pop_front();
          if ({out1_last, out1_data} !== e) begin
            errors++;
            $display("FAIL out1_beat got=%h exp=%h", {out1_last, out1_data}, e);
          end
        end
      end
    end
  end

  // Drive one beat (entered and left just after a rising edge)
  task automatic send(input logic [7:0] d, input logic l, input logic s);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    sel      = s;
    while (!done && n < 100) begin
      @(negedge clk);
      done = (in_ready === 1'b1);
      @(posedge clk);
      n++;
      if (done) model_accept(d, l, s);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout data=%h in_ready=%b", d, in_ready);
    end
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
    sel      = 1'($urandom);
  endtask

  task automatic wait_drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending q0=%0d q1=%0d exp 0 0", name, q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out0_data !== 8'h00 ||
        out1_data !== 8'h00 || out0_last !== 1'b0 || out1_last !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v0=%b v1=%b d0=%h d1=%h l0=%b l1=%b rdy=%b exp 0 0 00 00 0 0 1",
               out0_valid, out1_valid, out0_data, out1_data, out0_last, out1_last, in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(8'hA5, 1'b1, 1'b1);
    checks++;
    if (out1_valid !== 1'b1 || out1_data !== 8'hA5 || out1_last !== 1'b1 || out0_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_beat got v1=%b d1=%h l1=%b v0=%b exp 1 a5 1 0",
               out1_valid, out1_data, out1_last, out0_valid);
    end
    wait_drain("single_beat");
  endtask

  task automatic test_sel_lock();
    int s0;
    int s1;
    s0 = h0;
    s1 = h1;
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b1);
    send(8'h03, 1'b0, 1'b1);
    send(8'h04, 1'b1, 1'b1);
    send(8'h11, 1'b1, 1'b1);
    wait_drain("sel_lock");
    checks++;
    if (h0 - s0 != 4 || h1 - s1 != 1) begin
      errors++;
      $display("FAIL sel_lock_counts got out0=%0d out1=%0d exp 4 1", h0 - s0, h1 - s1);
    end
  endtask

  task automatic test_backpressure();
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    send(8'h21, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h22;
    in_last  = 1'b1;
    sel      = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out0_valid !== 1'b1 || out0_data !== 8'h21) begin
        errors++;
        $display("FAIL bp_stall got rdy=%b v0=%b d0=%h exp 0 1 21", in_ready, out0_valid, out0_data);
      end
      @(posedge clk);
    end
    #1;
    out0_ready = 1'b1;
    send(8'h22, 1'b1, 1'b1);
    out0_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h31;
    in_last  = 1'b1;
    sel      = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out0_valid !== 1'b1 || out0_data !== 8'h22) begin
      errors++;
      $display("FAIL bp_other_out got rdy=%b v0=%b d0=%h exp 1 1 22", in_ready, out0_valid, out0_data);
    end
    send(8'h31, 1'b1, 1'b1);
    out0_ready = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_full_rate();
    int s0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    s0 = h0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h80 + i);
      in_last  = (i == 15);
      sel      = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL full_rate_ready beat=%0d got=%b exp 1", i, in_ready);
      end
      @(posedge clk);
      model_accept(8'(8'h80 + i), (i == 15), 1'b0);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (h0 - s0 != 16) begin
      errors++;
      $display("FAIL full_rate_count got=%0d exp 16", h0 - s0);
    end
    wait_drain("full_rate");
  endtask

  task automatic test_random();
    int len;
    logic s;
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          out0_ready = 1'($urandom);
          out1_ready = 1'($urandom);
        end
      end
    join_none
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 4);
      s = 1'($urandom);
      for (int b = 0; b < len; b++) begin
        send(8'($urandom), (b == len - 1), (b == 0) ? s : 1'($urandom));
      end
    end
    rand_on = 1'b0;
    @(posedge clk);
    #2;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    wait_drain("random");
  endtask

  task automatic test_reset_mid_packet();
    int s0;
    int s1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    send(8'h41, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'h42;
    in_last  = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || out1_data !== 8'h00 || out1_last !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got v0=%b v1=%b d1=%h l1=%b exp 0 0 00 0",
               out0_valid, out1_valid, out1_data, out1_last);
    end
    s0 = h0;
    s1 = h1;
    send(8'h51, 1'b1, 1'b0);
    wait_drain("midrst");
    checks++;
    if (h0 - s0 != 1 || h1 - s1 != 0) begin
      errors++;
      $display("FAIL midrst_idle got out0=%0d out1=%0d exp 1 0", h0 - s0, h1 - s1);
    end
`ifdef DEMUX_STATS_EN
    send(8'h61, 1'b0, 1'b1);
    send(8'h62, 1'b1, 1'b0);
    send(8'h63, 1'b1, 1'b1);
    send(8'h64, 1'b0, 1'b1);
    send(8'h65, 1'b0, 1'b0);
    send(8'h66, 1'b1, 1'b0);
    wait_drain("stats");
    checks++;
    if (out1_pkt_cnt !== 16'd3 || out0_pkt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL stats_cnt got c0=%0d c1=%0d exp 1 3", out0_pkt_cnt, out1_pkt_cnt);
    end
`endif
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_last    = 1'b0;
    sel        = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single_beat();
    test_sel_lock();
    test_backpressure();
    test_full_rate();
    test_random();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
